aes_128_core: RTL and testbench
===============================

# aes_128_core

Fully pipelined AES-128 encryption datapath (FIPS-197, encrypt only). It accepts a 128-bit plaintext block and a 128-bit key every clock, and returns the ciphertext a fixed number of cycles later. It sits behind any framing or valid logic, which the surrounding design tracks by counting the fixed latency. The core has no handshake and no stall.

## Interface
- Parameters: none.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock for all registers.
- `rst_n`  in  1  asynchronous active-low reset; clears every pipeline register.
- `state`  in  128  plaintext block; bit 127 is byte 0 (FIPS byte order, MSB first).
- `key`  in  128  cipher key, same byte ordering.
- `out`  out  128  ciphertext, same byte ordering; registered output.

## Operation
- Stage 0 registers `s0 = state ^ key` and `k0 = key` on every rising edge.
- Stages i = 1..10 each do the following:
  - Compute the round key `K_i = expand(k_{i-1}, rcon_i)` combinationally.
  - Register `k_i = K_i`.
  - Register `s_i = round_i(s_{i-1}, K_i)`.
- `expand`:
  - w3' = SubWord(RotWord(w3)) ^ {rcon_i, 00, 00, 00}.
  - w0n = w0 ^ w3'; w1n = w1 ^ w0n; w2n = w2 ^ w1n; w3n = w3 ^ w2n.
  - rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Rounds 1..9: SubBytes, ShiftRows, MixColumns, then AddRoundKey.
- Round 10: SubBytes, ShiftRows, AddRoundKey; no MixColumns.
- `out = s10`.
- MixColumns arithmetic is in GF(2^8) with polynomial 0x11b; xtime(b) = (b<<1) ^ (b[7] ? 0x1b : 0).
- S-box is the standard FIPS-197 forward table, implemented as a pure combinational lookup.
- `state` and `key` are sampled together every cycle. A different key per block is allowed; the key travels with its block.

## Timing
- Throughput: one block per clock, no bubbles.
- Latency: inputs sampled at rising edge t appear on `out` after rising edge t+10, i.e. 11 register stages.
- Reset (`rst_n` low, asynchronous assertion):
  - All s_i and k_i clear to 0, so `out` = 0 immediately.
  - On release, the pipeline refills. `out` carries transformed zero contents for the first 10 edges; downstream logic ignores it.
- Reset mid-stream: all in-flight blocks are discarded. No partial results are retained.
- No X propagation after reset: every register has a reset value.

## Structure
- Package `aes_pkg`:
  - `sbox(byte)` function.
  - `xtime` and `mix_column(word)` functions.
  - `RCON[1:10]` constant array.
- Sub-module `aes_round_stage`:
  - Parameters: round index and final-round flag.
  - Contains key expansion, round transform and the two 128-bit registers.
  - Instantiated 10 times by generate.
- Top level: stage 0 registers plus the chain of `aes_round_stage` instances.

## Test plan
- FIPS-197 App. B: state=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c held; 11 edges -> out=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 C.1: state=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> out=69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero state and key -> out=66e94bd4ef8a2c3b884cfa59ca342b2e.
- Streaming: present the App. B, C.1 and all-zero vectors on consecutive cycles. `out` must show the three ciphertexts on consecutive cycles, starting 11 edges after the first.
- Reset: assert `rst_n` low mid-stream, between clock edges. `out` goes to 0 at once, without waiting for a clock edge. After release, the first fresh input yields the correct ciphertext exactly 11 edges later.
- Per-block key change: same plaintext with two different keys on consecutive cycles -> two independent, correct ciphertexts.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers: forward S-box, xtime,
// MixColumns on one column and the round-constant table.
package aes_pkg;

  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NUM_ROUNDS = 10;

  localparam logic [BYTE_W-1:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [BYTE_W-1:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [BYTE_W-1:0] sbox(input logic [BYTE_W-1:0] b);
    return SBOX_TABLE[b];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [WORD_W-1:0] mix_column(input logic [WORD_W-1:0] col);
    logic [BYTE_W-1:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_round_stage.sv
// One AES-128 pipeline stage: expands the next round key and applies one
// round to the block, registering both so the key travels with its block.
module aes_round_stage
  import aes_pkg::*;
#(
  parameter int unsigned ROUND = 1,
  parameter bit          FINAL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] i_state,
  input  logic [BLOCK_W-1:0] i_key,
  output logic [BLOCK_W-1:0] o_state,
  output logic [BLOCK_W-1:0] o_key
);

  logic [WORD_W-1:0]  w_temp;
  logic [BLOCK_W-1:0] w_round_key;
  logic [BLOCK_W-1:0] w_sub;
  logic [BLOCK_W-1:0] w_shift;
  logic [BLOCK_W-1:0] w_mix;
  logic [BLOCK_W-1:0] w_next_state;
  logic [BLOCK_W-1:0] r_state;
  logic [BLOCK_W-1:0] r_key;

  // SubWord(RotWord(w3)) ^ rcon, then the chained word XORs.
  always_comb begin
    w_temp = {sbox(i_key[23:16]), sbox(i_key[15:8]), sbox(i_key[7:0]), sbox(i_key[31:24])}
             ^ {RCON[ROUND], 24'h000000};
    w_round_key          = '0;
    w_round_key[127:96]  = i_key[127:96] ^ w_temp;
    w_round_key[95:64]   = i_key[95:64]  ^ w_round_key[127:96];
    w_round_key[63:32]   = i_key[63:32]  ^ w_round_key[95:64];
    w_round_key[31:0]    = i_key[31:0]   ^ w_round_key[63:32];
  end

  // Byte n lives at bits [127-8n -: 8]; row r, column c is byte r+4c.
  always_comb begin
    w_sub   = '0;
    w_shift = '0;
    w_mix   = '0;
    for (int n = 0; n < 16; n++) begin
      w_sub[127-8*n -: 8] = sbox(i_state[127-8*n -: 8]);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_shift[127-8*(r+4*c) -: 8] = w_sub[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mix[127-32*c -: 32] = mix_column(w_shift[127-32*c -: 32]);
    end
    w_next_state = (FINAL ? w_shift : w_mix) ^ w_round_key;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_key   <= '0;
    end else begin
      r_state <= w_next_state;
      r_key   <= w_round_key;
    end
  end

  assign o_state = r_state;
  assign o_key   = r_key;

endmodule

// File: rtl/aes_128_core.sv
// Fully pipelined AES-128 encryptor: initial AddRoundKey stage followed by
// ten round stages; one block in and one block out per clock, 11-cycle latency.
module aes_128_core
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] key,
  output logic [BLOCK_W-1:0] out
);

  logic [BLOCK_W-1:0] r_s0;
  logic [BLOCK_W-1:0] r_k0;
  logic [BLOCK_W-1:0] w_state [0:NUM_ROUNDS];
  logic [BLOCK_W-1:0] w_key   [0:NUM_ROUNDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= '0;
      r_k0 <= '0;
    end else begin
      r_s0 <= state ^ key;
      r_k0 <= key;
    end
  end

  assign w_state[0] = r_s0;
  assign w_key[0]   = r_k0;

  for (genvar gi = 1; gi <= int'(NUM_ROUNDS); gi++) begin : g_round
    aes_round_stage #(
      .ROUND (gi),
      .FINAL (gi == int'(NUM_ROUNDS))
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_state (w_state[gi-1]),
      .i_key   (w_key[gi-1]),
      .o_state (w_state[gi]),
      .o_key   (w_key[gi])
    );
  end

  assign out = w_state[NUM_ROUNDS];

endmodule

// File: tb/tb_aes_128_core.sv
// Directed-vector bench for aes_128_core using FIPS-197 and NIST known answers.
module tb_aes_128_core;

  logic         clk;
  logic         rst_n;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;

  int n_cmp;
  int n_err;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] KEY_V = 128'h80000000000000000000000000000000;
  localparam logic [127:0] CT_V  = 128'h0edd33d3c621e546455bd8ba1418bec8;

  aes_128_core u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .state (state),
    .key   (key),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    state = '0;
    key   = '0;
    #2;
    n_cmp++;
    if (out !== 128'h0) begin
      $display("FAIL reset_initial: got %h expected %h", out, 128'h0);
      n_err++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips_b();
    @(negedge clk);
    state = PT_B;
    key   = KEY_B;
    repeat (11) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out !== CT_B) begin
      $display("FAIL fips_b: got %h expected %h", out, CT_B);
      n_err++;
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (out !== CT_B) begin
      $display("FAIL fips_b_held: got %h expected %h", out, CT_B);
      n_err++;
    end
  endtask

  task automatic test_fips_c1();
    @(negedge clk);
    state = PT_C;
    key   = KEY_C;
    repeat (11) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out !== CT_C) begin
      $display("FAIL fips_c1: got %h expected %h", out, CT_C);
      n_err++;
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    state = '0;
    key   = '0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out !== CT_Z) begin
      $display("FAIL all_zero: got %h expected %h", out, CT_Z);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    state = PT_B;
    key   = KEY_B;
    @(negedge clk);
    state = PT_C;
    key   = KEY_C;
    @(negedge clk);
    state = '0;
    key   = '0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out !== CT_B) begin
      $display("FAIL stream_0: got %h expected %h", out, CT_B);
      n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (out !== CT_C) begin
      $display("FAIL stream_1: got %h expected %h", out, CT_C);
      n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (out !== CT_Z) begin
      $display("FAIL stream_2: got %h expected %h", out, CT_Z);
      n_err++;
    end
  endtask

  task automatic test_key_change();
    @(negedge clk);
    state = '0;
    key   = '0;
    @(negedge clk);
    state = '0;
    key   = KEY_V;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out !== CT_Z) begin
      $display("FAIL key_change_0: got %h expected %h", out, CT_Z);
      n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (out !== CT_V) begin
      $display("FAIL key_change_1: got %h expected %h", out, CT_V);
      n_err++;
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    state = PT_B;
    key   = KEY_B;
    @(negedge clk);
    state = PT_C;
    key   = KEY_C;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out !== 128'h0) begin
      $display("FAIL reset_async: got %h expected %h", out, 128'h0);
      n_err++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out !== 128'h0) begin
      $display("FAIL reset_held: got %h expected %h", out, 128'h0);
      n_err++;
    end
    rst_n = 1'b1;
    state = '0;
    key   = '0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out !== CT_Z) begin
      $display("FAIL reset_refill: got %h expected %h", out, CT_Z);
      n_err++;
    end
    state = PT_B;
    key   = KEY_B;
    repeat (11) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out !== CT_B) begin
      $display("FAIL reset_after: got %h expected %h", out, CT_B);
      n_err++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_zero();
    test_back_to_back();
    test_key_change();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
